// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder: WIDTH-bit add stepped 4 bits/cycle through one cla_adder_4bit (rev 1.0).
// Define NIBBLE_SERIAL_SUB_EN to enable A-B via the sub input.
`default_nettype none

module cla_adder_4bit (
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  input  logic       i_cin,
  output logic [3:0] o_s,
  output logic       o_c4,
  output logic       o_pg,
  output logic       o_gg
);
  logic [3:0] w_g;
  logic [3:0] w_p;
  logic [3:0] w_c;

  assign w_g = i_a & i_b;
  assign w_p = i_a ^ i_b;

  assign w_c[0] = i_cin;
  assign w_c[1] = w_g[0] | (w_p[0] & i_cin);
  assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & i_cin);
  assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                | (w_p[2] & w_p[1] & w_p[0] & i_cin);

  assign o_pg = &w_p;
  assign o_gg = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
              | (w_p[3] & w_p[2] & w_p[1] & w_g[0]);
  assign o_c4 = o_gg | (o_pg & i_cin);
  assign o_s  = w_p ^ w_c;
endmodule

module nibble_serial_adder #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);
  localparam int NIB = WIDTH / 4;
  localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_carry;
  logic [IW-1:0]    r_idx;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_ovf;
  logic             r_zero;

  logic [3:0]       w_a_nib;
  logic [3:0]       w_b_nib;
  logic [3:0]       w_s;
  logic             w_c4;
  logic             w_pg;
  logic             w_gg;
  logic             w_last;
  logic [WIDTH-1:0] w_sum_next;
  logic             w_unused_pg_gg;

  assign w_unused_pg_gg = w_pg ^ w_gg;

`ifndef NIBBLE_SERIAL_SUB_EN
  logic w_unused_sub;
  assign w_unused_sub = sub;
`endif

  assign w_last = (r_idx == IW'(NIB - 1));

  always_comb begin
    w_a_nib    = '0;
    w_b_nib    = '0;
    w_sum_next = r_sum;
    for (int k = 0; k < NIB; k++) begin
      if (r_idx == IW'(k)) begin
        w_a_nib             = r_a[4*k +: 4];
        w_b_nib             = r_b[4*k +: 4];
        w_sum_next[4*k +: 4] = w_s;
      end
    end
  end

  cla_adder_4bit u_cla (
    .i_a   (w_a_nib),
    .i_b   (w_b_nib),
    .i_cin (r_carry),
    .o_s   (w_s),
    .o_c4  (w_c4),
    .o_pg  (w_pg),
    .o_gg  (w_gg)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (in_valid)  w_next = RUN;
      RUN:     if (w_last)    w_next = DONE;
      DONE:    if (out_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_a     <= '0;
      r_b     <= '0;
      r_carry <= 1'b0;
      r_idx   <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
      r_zero  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a   <= a;
            r_idx <= '0;
`ifdef NIBBLE_SERIAL_SUB_EN
            // Subtract as A + ~B + 1; cout then reads as "no borrow".
            r_b     <= sub ? ~b : b;
            r_carry <= sub ? 1'b1 : cin;
`else
            r_b     <= b;
            r_carry <= cin;
`endif
          end
        end
        RUN: begin
          r_sum   <= w_sum_next;
          r_carry <= w_c4;
          r_idx   <= r_idx + IW'(1);
          if (w_last) begin
            r_cout <= w_c4;
            r_ovf  <= (r_a[WIDTH-1] == r_b[WIDTH-1]) && (w_s[3] != r_a[WIDTH-1]);
            r_zero <= (w_sum_next == '0);
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign sum       = r_sum;
  assign cout      = r_cout;
  assign ovf       = r_ovf;
  assign zero      = r_zero;
endmodule

`default_nettype wire

// File: tb/tb_nibble_serial_adder.sv
// tb_nibble_serial_adder: table vectors, corner sequences and random ops vs. an arithmetic model.
`default_nettype none

module tb_nibble_serial_adder;
  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        cin = 1'b0;
  logic        sub = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] sum;
  logic        cout;
  logic        ovf;
  logic        zero;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  nibble_serial_adder #(.WIDTH(32)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf),
    .zero      (zero)
  );

  typedef struct {
    logic [31:0] va;
    logic [31:0] vb;
    logic        vc;
    logic        vs;
    logic [31:0] es;
    logic        eco;
    logic        eov;
    logic        ez;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", nm, got, exp);
    end
  endtask

  // Reference: signed/unsigned integer arithmetic on the whole word.
  function automatic vec_t model(input logic [31:0] va, input logic [31:0] vb,
                                 input logic vc, input logic vs);
    vec_t   v;
    longint sa;
    longint sb;
    longint r;
    logic   do_sub;
    do_sub = 1'b0;
`ifdef NIBBLE_SERIAL_SUB_EN
    do_sub = vs;
`endif
    sa = longint'($signed(va));
    sb = longint'($signed(vb));
    v.va = va; v.vb = vb; v.vc = vc; v.vs = vs;
    if (do_sub) begin
      r     = sa - sb;
      v.eco = (va >= vb);
    end else begin
      r     = sa + sb + longint'(vc);
      v.eco = (({32'b0, va} + {32'b0, vb} + 64'(vc)) > 64'hFFFF_FFFF);
    end
    v.es  = r[31:0];
    v.eov = (r > 64'sd2147483647) || (r < -64'sd2147483648);
    v.ez  = (v.es == 32'h0);
    return v;
  endfunction

  // Called at a negedge; returns at the negedge right after the accepting edge.
  task automatic launch(input logic [31:0] va, input logic [31:0] vb,
                        input logic vc, input logic vs);
    int w;
    w = 0;
    while (!in_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL in_ready_timeout: got 0, required 1");
    end
    a = va; b = vb; cin = vc; sub = vs;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    a   = $urandom;
    b   = $urandom;
    cin = 1'($urandom_range(0, 1));
    sub = 1'($urandom_range(0, 1));
  endtask

  task automatic collect(input string nm, input logic [31:0] es,
                         input logic eco, input logic eov, input logic ez);
    int lat;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk({nm, "_latency"}, 64'(lat), 64'd8);
    chk({nm, "_sum"}, 64'(sum), 64'(es));
    chk({nm, "_cout"}, 64'(cout), 64'(eco));
    chk({nm, "_ovf"}, 64'(ovf), 64'(eov));
    chk({nm, "_zero"}, 64'(zero), 64'(ez));
    chk({nm, "_in_ready_busy"}, 64'(in_ready), 64'd0);
    if (out_ready) @(negedge clk);
  endtask

  initial begin
    vec_t m;
    logic [31:0] held;

    vq.push_back('{32'h0000_0005, 32'h0000_000A, 1'b0, 1'b0, 32'h0000_000F, 1'b0, 1'b0, 1'b0});
    vq.push_back('{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1});
    vq.push_back('{32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1});
    vq.push_back('{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0});
    vq.push_back('{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b1});
`ifdef NIBBLE_SERIAL_SUB_EN
    vq.push_back('{32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0});
    vq.push_back('{32'h0000_0007, 32'h0000_0005, 1'b0, 1'b1, 32'h0000_0002, 1'b1, 1'b0, 1'b0});
    vq.push_back('{32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0});
`else
    vq.push_back('{32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'h0000_000C, 1'b0, 1'b0, 1'b0});
`endif

    repeat (3) @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_sum", 64'(sum), 64'd0);
    chk("rst_cout", 64'(cout), 64'd0);
    chk("rst_ovf", 64'(ovf), 64'd0);
    chk("rst_zero", 64'(zero), 64'd0);
    rstn = 1'b1;
    @(negedge clk);

    for (int i = 0; i < vq.size(); i++) begin
      launch(vq[i].va, vq[i].vb, vq[i].vc, vq[i].vs);
      collect($sformatf("vec%0d", i), vq[i].es, vq[i].eco, vq[i].eov, vq[i].ez);
    end

    // Backpressure with a competing request waiting in DONE.
    out_ready = 1'b0;
    launch(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0);
    collect("bp1", 32'h2345_6789, 1'b0, 1'b0, 1'b0);
    a = 32'h1; b = 32'h2; cin = 1'b0; sub = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_hold_sum", 64'(sum), 64'h2345_6789);
      chk("bp_hold_valid", 64'(out_valid), 64'd1);
      chk("bp_hold_in_ready", 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_in_ready", 64'(in_ready), 64'd1);
    chk("bp_release_valid", 64'(out_valid), 64'd0);
    @(negedge clk);
    in_valid = 1'b0;
    chk("bp_second_accepted", 64'(in_ready), 64'd0);
    collect("bp2", 32'h3, 1'b0, 1'b0, 1'b0);

    // Reset in the third RUN cycle discards the partial result.
    launch(32'hDEAD_BEEF, 32'h0000_1111, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    rstn = 1'b0;
    #1;
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_in_ready", 64'(in_ready), 64'd1);
    chk("midrst_sum", 64'(sum), 64'd0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    launch(32'd3, 32'd4, 1'b0, 1'b0);
    collect("after_rst", 32'd7, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 30; i++) begin
      logic [31:0] ra;
      logic [31:0] rb;
      ra = (i % 7 == 0) ? 32'hFFFF_FFFF : $urandom;
      rb = (i % 5 == 0) ? 32'h8000_0000 : $urandom;
      m = model(ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      out_ready = 1'($urandom_range(0, 1));
      launch(m.va, m.vb, m.vc, m.vs);
      collect($sformatf("rnd%0d", i), m.es, m.eco, m.eov, m.ez);
      if (!out_ready) begin
        held = sum;
        repeat ($urandom_range(1, 3)) @(negedge clk);
        chk($sformatf("rnd%0d_held", i), 64'(sum), 64'(m.es));
        out_ready = 1'b1;
        @(negedge clk);
        chk($sformatf("rnd%0d_stable", i), 64'(held), 64'(m.es));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

`default_nettype wire
